// File: rtl/sdram_timing_pkg.sv
// Shared SDRAM controller state encodings and widths for the timing block.
package sdram_timing_pkg;

    localparam int unsigned STATE_W   = 5;
    localparam int unsigned ELAPSED_W = 4;

    // Init sequence states
    localparam logic [STATE_W-1:0] I_POWON    = 5'd0;
    localparam logic [STATE_W-1:0] I_PRE_CMD  = 5'd1;
    localparam logic [STATE_W-1:0] I_PRE_TRP  = 5'd2;
    localparam logic [STATE_W-1:0] I_AR0_CMD  = 5'd3;
    localparam logic [STATE_W-1:0] I_AR0_TRFC = 5'd4;
    localparam logic [STATE_W-1:0] I_AR1_CMD  = 5'd5;
    localparam logic [STATE_W-1:0] I_AR1_TRFC = 5'd6;
    localparam logic [STATE_W-1:0] I_MRS_CMD  = 5'd7;
    localparam logic [STATE_W-1:0] I_MRS_TMRD = 5'd8;
    localparam logic [STATE_W-1:0] I_DONE     = 5'd9;

    // Work (normal operation) states
    localparam logic [STATE_W-1:0] S_IDLE     = 5'd0;
    localparam logic [STATE_W-1:0] S_REF_CMD  = 5'd1;
    localparam logic [STATE_W-1:0] S_TRFC     = 5'd2;
    localparam logic [STATE_W-1:0] S_REF_CMD1 = 5'd3;
    localparam logic [STATE_W-1:0] S_TRFC1    = 5'd4;
    localparam logic [STATE_W-1:0] S_ACT      = 5'd5;
    localparam logic [STATE_W-1:0] S_TRCD     = 5'd6;
    localparam logic [STATE_W-1:0] S_RD_CMD   = 5'd7;
    localparam logic [STATE_W-1:0] S_CL       = 5'd8;
    localparam logic [STATE_W-1:0] S_RD_DATA  = 5'd9;
    localparam logic [STATE_W-1:0] S_RWAIT    = 5'd10;
    localparam logic [STATE_W-1:0] S_WR_CMD   = 5'd11;
    localparam logic [STATE_W-1:0] S_WR_DATA  = 5'd12;
    localparam logic [STATE_W-1:0] S_TDAL     = 5'd13;

    // Saturating increment for the elapsed-cycles counter
    function automatic logic [ELAPSED_W-1:0] sat_inc(input logic [ELAPSED_W-1:0] v);
        return (v == '1) ? v : v + ELAPSED_W'(1);
    endfunction

endpackage

// File: rtl/sdram_timing_if.sv
// Controller <-> timing block bundle: state inputs, refresh handshake, wait-end strobes.
interface sdram_timing_if;
    import sdram_timing_pkg::*;

    logic [STATE_W-1:0] init_state;
    logic [STATE_W-1:0] work_state;
    logic               sdram_ref_ack;
    logic               done_200us;
    logic               sdram_ref_req;
    logic               ref_domain;
    logic               end_trp;
    logic               end_trfc;
    logic               end_tmrd;
    logic               end_trcd;
    logic               end_tcl;
    logic               end_tread;
    logic               end_twait;
    logic               end_twrite;
    logic               end_tdal;

    modport slave (
        input  init_state, work_state, sdram_ref_ack,
        output done_200us, sdram_ref_req, ref_domain,
        output end_trp, end_trfc, end_tmrd, end_trcd, end_tcl,
        output end_tread, end_twait, end_twrite, end_tdal
    );

    modport master (
        output init_state, work_state, sdram_ref_ack,
        input  done_200us, sdram_ref_req, ref_domain,
        input  end_trp, end_trfc, end_tmrd, end_trcd, end_tcl,
        input  end_tread, end_twait, end_twrite, end_tdal
    );

endinterface

// File: rtl/sdram_timing_ref_timer.sv
// Free-running refresh interval counter with a sticky request cleared by ack.
module sdram_timing_ref_timer #(
    parameter int unsigned TREF      = 1040,
    parameter int unsigned REF_GUARD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic ref_ack,
    output logic ref_req,
    output logic ref_domain_c
);

    localparam int unsigned REF_W = $clog2(TREF + 1);
    localparam logic [REF_W-1:0] CNT_LAST  = REF_W'(TREF - 1);
    localparam logic [REF_W-1:0] CNT_GUARD = REF_W'(TREF - REF_GUARD);

    logic [REF_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             wrap_c;

    // Wrap wins over a same-cycle ack so a new interval is never lost
    always_comb begin
        wrap_c = run && (cnt_q == CNT_LAST);
        cnt_d  = '0;
        if (run && !wrap_c) begin
            cnt_d = cnt_q + REF_W'(1);
        end
        req_d = wrap_c | (req_q & ~ref_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign ref_req      = req_q;
    assign ref_domain_c = req_q | (cnt_q >= CNT_GUARD);

endmodule

// File: rtl/sdram_timing.sv
// SDRAM command-spacing timer: power-up wait, per-state wait-end strobes and refresh pacing.
module sdram_timing
    import sdram_timing_pkg::*;
#(
    parameter int unsigned T200US    = 26600,
    parameter int unsigned TREF      = 1040,
    parameter int unsigned REF_GUARD = 16,
    parameter int unsigned TRP       = 3,
    parameter int unsigned TRFC      = 9,
    parameter int unsigned TMRD      = 2,
    parameter int unsigned TRCD      = 3,
    parameter int unsigned TCL       = 3,
    parameter int unsigned BL        = 4,
    parameter int unsigned TDAL      = 5
) (
    input logic           clk,
    input logic           rst_n,
    sdram_timing_if.slave tif
);

    localparam int unsigned PWR_W  = 15;
    localparam int unsigned PAIR_W = 2 * STATE_W;

    localparam logic [PWR_W-1:0]     PWR_LAST = PWR_W'(T200US - 1);
    localparam logic [PAIR_W-1:0]    PAIR_RST = {I_POWON, S_IDLE};
    localparam logic [ELAPSED_W-1:0] E_TRP    = ELAPSED_W'(TRP - 2);
    localparam logic [ELAPSED_W-1:0] E_TRFC   = ELAPSED_W'(TRFC - 2);
    localparam logic [ELAPSED_W-1:0] E_TMRD   = ELAPSED_W'(TMRD - 2);
    localparam logic [ELAPSED_W-1:0] E_TRCD   = ELAPSED_W'(TRCD - 2);
    localparam logic [ELAPSED_W-1:0] E_TCL    = ELAPSED_W'(TCL - 2);
    localparam logic [ELAPSED_W-1:0] E_TREAD  = ELAPSED_W'(BL - 1);
    localparam logic [ELAPSED_W-1:0] E_TWRITE = ELAPSED_W'(BL - 2);
    localparam logic [ELAPSED_W-1:0] E_TDAL   = ELAPSED_W'(TDAL - 1);

    logic [PWR_W-1:0]     pwr_cnt_q, pwr_cnt_d;
    logic                 done_q, done_d;
    logic [PAIR_W-1:0]    pair_q, pair_d;
    logic [ELAPSED_W-1:0] held_q, held_d;
    logic [ELAPSED_W-1:0] elapsed_c;
    logic                 run_q, run_d;
    logic                 ref_run_c;
    logic                 ref_req_c;
    logic                 ref_domain_c;

    logic end_trp_c, end_trfc_c, end_tmrd_c, end_trcd_c, end_tcl_c;
    logic end_tread_c, end_twait_c, end_twrite_c, end_tdal_c;

    // Elapsed restarts at 0 whenever the state pair differs from last cycle
    always_comb begin
        pair_d    = {tif.init_state, tif.work_state};
        elapsed_c = (pair_d == pair_q) ? held_q : '0;
        held_d    = sat_inc(elapsed_c);
        pwr_cnt_d = (pwr_cnt_q == '1) ? pwr_cnt_q : pwr_cnt_q + PWR_W'(1);
        done_d    = done_q | (pwr_cnt_q == PWR_LAST);
        run_d     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_cnt_q <= '0;
            done_q    <= 1'b0;
            pair_q    <= PAIR_RST;
            held_q    <= '0;
            run_q     <= 1'b0;
        end else begin
            pwr_cnt_q <= pwr_cnt_d;
            done_q    <= done_d;
            pair_q    <= pair_d;
            held_q    <= held_d;
            run_q     <= run_d;
        end
    end

    // run_q is cleared asynchronously, so every strobe drops the moment reset asserts
    always_comb begin
        end_trp_c    = 1'b0;
        end_trfc_c   = 1'b0;
        end_tmrd_c   = 1'b0;
        end_trcd_c   = 1'b0;
        end_tcl_c    = 1'b0;
        end_tread_c  = 1'b0;
        end_twait_c  = 1'b0;
        end_twrite_c = 1'b0;
        end_tdal_c   = 1'b0;
        if (run_q) begin
            end_trp_c    = (tif.init_state == I_PRE_TRP) && (elapsed_c == E_TRP);
            end_trfc_c   = ((tif.init_state == I_AR0_TRFC) || (tif.init_state == I_AR1_TRFC) ||
                            (tif.work_state == S_TRFC) || (tif.work_state == S_TRFC1)) &&
                           (elapsed_c == E_TRFC);
            end_tmrd_c   = (tif.init_state == I_MRS_TMRD) && (elapsed_c == E_TMRD);
            end_trcd_c   = (tif.work_state == S_TRCD) && (elapsed_c == E_TRCD);
            end_tcl_c    = (tif.work_state == S_CL) && (elapsed_c == E_TCL);
            end_tread_c  = (tif.work_state == S_RD_DATA) && (elapsed_c == E_TREAD);
            end_twait_c  = (tif.work_state == S_RWAIT) && (elapsed_c == E_TRP);
            end_twrite_c = (tif.work_state == S_WR_DATA) && (elapsed_c == E_TWRITE);
            end_tdal_c   = (tif.work_state == S_TDAL) && (elapsed_c == E_TDAL);
        end
    end

    assign ref_run_c = (tif.init_state == I_DONE);

    sdram_timing_ref_timer #(
        .TREF      (TREF),
        .REF_GUARD (REF_GUARD)
    ) u_ref_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (ref_run_c),
        .ref_ack      (tif.sdram_ref_ack),
        .ref_req      (ref_req_c),
        .ref_domain_c (ref_domain_c)
    );

    assign tif.done_200us    = done_q;
    assign tif.sdram_ref_req = ref_req_c;
    assign tif.ref_domain    = run_q & ref_domain_c;
    assign tif.end_trp       = end_trp_c;
    assign tif.end_trfc      = end_trfc_c;
    assign tif.end_tmrd      = end_tmrd_c;
    assign tif.end_trcd      = end_trcd_c;
    assign tif.end_tcl       = end_tcl_c;
    assign tif.end_tread     = end_tread_c;
    assign tif.end_twait     = end_twait_c;
    assign tif.end_twrite    = end_twrite_c;
    assign tif.end_tdal      = end_tdal_c;

endmodule

// File: tb/tb_sdram_timing.sv
// Self-checking bench for sdram_timing: expected strobes/flags queued with stimulus, compared on output.
module tb_sdram_timing;
    import sdram_timing_pkg::*;

    localparam int B_TRP = 8, B_TRFC = 7, B_TMRD = 6, B_TRCD = 5, B_TCL = 4;
    localparam int B_TREAD = 3, B_TWAIT = 2, B_TWRITE = 1, B_TDAL = 0;

    typedef struct {
        logic [8:0] ends;
        string      tag;
    } exp_t;

    typedef struct {
        int adv;
        bit ack;
        bit req;
        bit dom;
    } ref_step_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    exp_t       sb_exp[$];
    logic [8:0] sb_obs[$];

    sdram_timing_if tif ();

    sdram_timing #(
        .T200US    (100),
        .TREF      (50),
        .REF_GUARD (5),
        .TRP       (3),
        .TRFC      (9),
        .TMRD      (2),
        .TRCD      (3),
        .TCL       (3),
        .BL        (4),
        .TDAL      (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ends_now();
        return {tif.end_trp, tif.end_trfc, tif.end_tmrd, tif.end_trcd, tif.end_tcl,
                tif.end_tread, tif.end_twait, tif.end_twrite, tif.end_tdal};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold a state pair for n cycles; expected strobe bit_idx only at cycle end_idx
    task automatic run_state(input logic [4:0] ist, input logic [4:0] wst, input int n,
                             input int end_idx, input int bit_idx, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            tif.init_state = ist;
            tif.work_state = wst;
            e.ends = '0;
            if (i == end_idx) e.ends[bit_idx] = 1'b1;
            e.tag = $sformatf("%s[%0d]", tag, i);
            sb_exp.push_back(e);
            #1;
            sb_obs.push_back(ends_now());
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tif.init_state = I_MRS_TMRD;
        #1;
        checks++;
        if (ends_now() !== 9'd0) begin
            errors++; $display("FAIL reset_ends: got %b want %b", ends_now(), 9'd0);
        end
        checks++;
        if (tif.done_200us !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", tif.done_200us);
        end
        checks++;
        if (tif.sdram_ref_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b want 0", tif.sdram_ref_req);
        end
        checks++;
        if (tif.ref_domain !== 1'b0) begin
            errors++; $display("FAIL reset_dom: got %b want 0", tif.ref_domain);
        end
        tif.init_state = I_POWON;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_powerup();
        int bad;
        repeat (99) tick();
        #1;
        checks++;
        if (tif.done_200us !== 1'b0) begin
            errors++; $display("FAIL pwr_at99: got %b want 0", tif.done_200us);
        end
        tick();
        #1;
        checks++;
        if (tif.done_200us !== 1'b1) begin
            errors++; $display("FAIL pwr_at100: got %b want 1", tif.done_200us);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            #1;
            if (tif.done_200us !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pwr_sticky: low in %0d cycles want 0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_init_seq();
        exp_t e;
        logic [8:0] o;
        run_state(I_PRE_CMD,  S_IDLE, 1, -1, 0, "pre_cmd");
        run_state(I_PRE_TRP,  S_IDLE, 4, 1, B_TRP, "pre_trp");
        run_state(I_AR0_CMD,  S_IDLE, 1, -1, 0, "ar0_cmd");
        run_state(I_AR0_TRFC, S_IDLE, 10, 7, B_TRFC, "ar0_trfc");
        run_state(I_AR1_CMD,  S_IDLE, 1, -1, 0, "ar1_cmd");
        run_state(I_AR1_TRFC, S_IDLE, 10, 7, B_TRFC, "ar1_trfc");
        run_state(I_MRS_CMD,  S_IDLE, 1, -1, 0, "mrs_cmd");
        run_state(I_MRS_TMRD, S_IDLE, 3, 0, B_TMRD, "mrs_tmrd");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front();
            checks++;
            if (o !== e.ends) begin
                errors++; $display("FAIL init %s: got %b want %b", e.tag, o, e.ends);
            end
        end
    endtask

    task automatic test_write();
        exp_t e;
        logic [8:0] o;
        run_state(I_DONE, S_IDLE,    2, -1, 0, "idle");
        run_state(I_DONE, S_ACT,     1, -1, 0, "act");
        run_state(I_DONE, S_TRCD,    3, 1, B_TRCD, "trcd");
        run_state(I_DONE, S_WR_CMD,  1, -1, 0, "wr_cmd");
        run_state(I_DONE, S_WR_DATA, 3, 2, B_TWRITE, "wr_data");
        run_state(I_DONE, S_TDAL,    6, 4, B_TDAL, "tdal");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front();
            checks++;
            if (o !== e.ends) begin
                errors++; $display("FAIL write %s: got %b want %b", e.tag, o, e.ends);
            end
        end
    endtask

    task automatic test_read();
        exp_t e;
        logic [8:0] o;
        run_state(I_DONE, S_ACT,     1, -1, 0, "act");
        run_state(I_DONE, S_TRCD,    3, 1, B_TRCD, "trcd");
        run_state(I_DONE, S_RD_CMD,  1, -1, 0, "rd_cmd");
        run_state(I_DONE, S_CL,      2, 1, B_TCL, "cl");
        run_state(I_DONE, S_RD_DATA, 6, 3, B_TREAD, "rd_data");
        run_state(I_DONE, S_RWAIT,   3, 1, B_TWAIT, "rwait");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front();
            checks++;
            if (o !== e.ends) begin
                errors++; $display("FAIL read %s: got %b want %b", e.tag, o, e.ends);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [8:0] o;
        run_state(I_DONE,    S_TRFC,  10, 7, B_TRFC, "trfc");
        run_state(I_DONE,    S_TRFC1, 20, 7, B_TRFC, "trfc1_hold");
        run_state(I_PRE_TRP, S_IDLE,  20, 1, B_TRP, "trp_hold");
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front();
            checks++;
            if (o !== e.ends) begin
                errors++; $display("FAIL b2b %s: got %b want %b", e.tag, o, e.ends);
            end
        end
    endtask

    task automatic test_refresh();
        ref_step_t steps[12];
        ref_step_t s;
        ref_step_t q[$];
        logic      got_req, got_dom;
        // Sampled refresh count after each row: 0,44,45,49,0,3,4,5,49,0,49,0
        steps = '{'{0, 1'b0, 1'b0, 1'b0}, '{44, 1'b0, 1'b0, 1'b0}, '{1, 1'b0, 1'b0, 1'b1},
                  '{4, 1'b0, 1'b0, 1'b1}, '{1, 1'b0, 1'b1, 1'b1}, '{3, 1'b0, 1'b1, 1'b1},
                  '{1, 1'b1, 1'b0, 1'b0}, '{1, 1'b1, 1'b0, 1'b0}, '{44, 1'b0, 1'b0, 1'b1},
                  '{1, 1'b1, 1'b1, 1'b1}, '{49, 1'b0, 1'b1, 1'b1}, '{1, 1'b1, 1'b1, 1'b1}};
        rst_n = 1'b0;
        tif.init_state = I_POWON;
        tif.work_state = S_IDLE;
        tif.sdram_ref_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tif.init_state = I_DONE;
        for (int r = 0; r < 12; r++) begin
            q.push_back(steps[r]);
            for (int k = 0; k < steps[r].adv; k++) begin
                tif.sdram_ref_ack = (k == 0) ? steps[r].ack : 1'b0;
                tick();
            end
            tif.sdram_ref_ack = 1'b0;
            #1;
            got_req = tif.sdram_ref_req;
            got_dom = tif.ref_domain;
            s = q.pop_front();
            checks++;
            if (got_req !== s.req) begin
                errors++; $display("FAIL ref_req row%0d: got %b want %b", r, got_req, s.req);
            end
            checks++;
            if (got_dom !== s.dom) begin
                errors++; $display("FAIL ref_dom row%0d: got %b want %b", r, got_dom, s.dom);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        tif.init_state = I_DONE;
        tif.work_state = S_TRFC;
        repeat (7) tick();
        #1;
        checks++;
        if (ends_now() !== 9'b010000000) begin
            errors++; $display("FAIL mid_pre_ends: got %b want %b", ends_now(), 9'b010000000);
        end
        checks++;
        if ({tif.done_200us, tif.sdram_ref_req} !== 2'b11) begin
            errors++; $display("FAIL mid_pre_flags: got %b want 11",
                               {tif.done_200us, tif.sdram_ref_req});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ends_now() !== 9'd0) begin
            errors++; $display("FAIL mid_rst_ends: got %b want %b", ends_now(), 9'd0);
        end
        checks++;
        if ({tif.done_200us, tif.sdram_ref_req, tif.ref_domain} !== 3'b000) begin
            errors++; $display("FAIL mid_rst_flags: got %b want 000",
                               {tif.done_200us, tif.sdram_ref_req, tif.ref_domain});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (99) tick();
        #1;
        checks++;
        if (tif.done_200us !== 1'b0) begin
            errors++; $display("FAIL mid_pwr_at99: got %b want 0", tif.done_200us);
        end
        tick();
        #1;
        checks++;
        if (tif.done_200us !== 1'b1) begin
            errors++; $display("FAIL mid_pwr_at100: got %b want 1", tif.done_200us);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        tif.init_state = I_POWON;
        tif.work_state = S_IDLE;
        tif.sdram_ref_ack = 1'b0;
        test_reset();
        test_powerup();
        test_init_seq();
        test_write();
        test_read();
        test_back_to_back();
        test_refresh();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_timing.md
SDRAM_TIMING -- requirements
Module: sdram_timing

Interface
REQ-001 SHALL have parameter T200US, default 26600, meaning power-up wait in clocks (200 us at 133 MHz).
REQ-002 SHALL have parameter TREF, default 1040, meaning refresh interval in clocks (7.8 us).
REQ-003 SHALL have parameter REF_GUARD, default 16, meaning clocks before refresh due in which ref_domain is high.
REQ-004 SHALL have parameters TRP=3, TRFC=9, TMRD=2, TRCD=3, TCL=3, BL=4, TDAL=5, meaning command spacing in clocks; each must be >=2.
REQ-005 SHALL have clk, input, 1, meaning the single clock.
REQ-006 SHALL have rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have init_state, input, 5, meaning the controller init state.
REQ-008 SHALL have work_state, input, 5, meaning the controller work state.
REQ-009 SHALL have sdram_ref_ack, input, 1, meaning refresh accepted (one cycle).
REQ-010 SHALL have done_200us, output, 1, meaning power-up wait elapsed.
REQ-011 SHALL have sdram_ref_req, output, 1, meaning refresh pending.
REQ-012 SHALL have ref_domain, output, 1, meaning refresh imminent or pending.
REQ-013 SHALL have end_trp, end_trfc, end_tmrd, end_trcd, end_tcl, end_tread, end_twait, end_twrite and end_tdal, each output, 1, meaning the wait for that state ends this cycle.

Function
REQ-014 SHALL have a 15-bit power-up counter that counts from 0 after reset and saturates; done_200us registered high once count reaches T200US-1, sticky until reset.
REQ-015 SHALL derive elapsed E, cycles the current {init_state,work_state} pair has been held: E=0 in the first cycle of a new value, +1 per cycle, saturating at 15.
REQ-016 SHALL compute end_* combinationally from state and E; a wait state preceded by a one-cycle command state ends at E==t-2, so command-to-next-command spacing is exactly t.
REQ-017 SHALL assert end_trp in I_PRE_TRP at E==TRP-2, and end_twait in S_RWAIT at E==TRP-2.
REQ-018 SHALL assert end_trfc in I_AR0_TRFC, I_AR1_TRFC, S_TRFC or S_TRFC1 at E==TRFC-2.
REQ-019 SHALL assert end_tmrd in I_MRS_TMRD at E==TMRD-2, end_trcd in S_TRCD at E==TRCD-2, and end_tcl in S_CL at E==TCL-2.
REQ-020 SHALL assert end_tread in S_RD_DATA at E==BL-1 (BL data cycles), end_twrite in S_WR_DATA at E==BL-2 (WR_CMD carries word 0), and end_tdal in S_TDAL at E==TDAL-1.
REQ-021 SHALL hold every end_* low in all other states and hold it for one cycle only; a state held past its end SHALL NOT re-assert (E saturates above threshold).
REQ-022 SHALL hold the refresh counter (0..TREF-1, wrapping) at 0 until init_state==I_DONE, then run freely.
REQ-023 SHALL register sdram_ref_req high on the wrap cycle and clear it on sdram_ref_ack.
REQ-024 SHALL make a simultaneous wrap and ack leave sdram_ref_req high; an ack while req is low SHALL be ignored.
REQ-025 SHALL make ref_domain = sdram_ref_req OR (refresh count >= TREF-REF_GUARD).

Reset
REQ-026 SHALL, while rst_n is low, clear the power-up counter, refresh counter, E and done_200us/sdram_ref_req, and set the previous-state register to {I_POWON,S_IDLE}.
REQ-027 SHALL hold all end_* and ref_domain low during reset.
REQ-028 SHALL, on reset mid-wait, drop all outputs asynchronously with no pending request surviving.

Structure
REQ-029 SHALL take I_* and S_* state encodings from shared sdram_param.v; timing parameters SHALL be module parameters overridable per clock frequency.
REQ-030 SHALL be one flat module; optionally sub-module sdram_ref_timer for the refresh counter/request.

Verification
REQ-031 SHALL cover power-up with T200US=100: done_200us rises in the cycle after count 99 and stays high for 1000 cycles.
REQ-032 SHALL cover the init sequence PRE_CMD->I_PRE_TRP: end_trp at the 2nd cycle after PRE_CMD; AR->I_AR0_TRFC: end_trfc in the 8th cycle after AR.
REQ-033 SHALL cover a write path: S_WR_CMD then S_WR_DATA gives end_twrite on the 3rd WR_DATA cycle; S_TDAL gives end_tdal on its 5th cycle.
REQ-034 SHALL cover a read path: S_CL end_tcl at E==1; S_RD_DATA held 6 cycles gives end_tread exactly once, at E==3.
REQ-035 SHALL cover refresh with TREF=50 and REF_GUARD=5 after I_DONE: ref_domain high from count 45, req set at wrap, ack 3 cycles later clears req; ack forced on the wrap cycle keeps req high.
REQ-036 SHALL cover rst_n pulsed low during S_TRFC: all outputs low immediately, done_200us restarts from 0.
